// File: rtl/dds_dac_pkg.sv
// dds_dac_pkg: shared DAC scheduler states, register addresses and default timing.
package dds_dac_pkg;
  typedef enum logic [2:0] {IDLE, SETUP, WRITE, HOLD, LOAD, DONE} dac_state_e;
  localparam logic DAC_ADDR_A = 1'b0;
  localparam logic DAC_ADDR_B = 1'b1;
  localparam int DAC_DW = 12;
  localparam int DAC_SETUP_CYC = 2;
  localparam int DAC_WR_CYC = 3;
  localparam int DAC_HOLD_CYC = 2;
  localparam int DAC_LOAD_CYC = 2;
  localparam int DAC_OVF_W = 8;
  function automatic int max4(input int a, input int b, input int c, input int d);
    int m;
    m = a > b ? a : b;
    m = m > c ? m : c;
    return m > d ? m : d;
  endfunction
endpackage

// File: rtl/dac_dual_write_sched_if.sv
// dac_dual_write_sched_if: DDS sample input and DAC pin bundle for the write scheduler.
interface dac_dual_write_sched_if import dds_dac_pkg::*; #(
  parameter int DW = DAC_DW,
  parameter int OVF_W = DAC_OVF_W
);
  logic enable;
  logic sample_tick;
  logic [DW-1:0] ch1_data;
  logic [DW-1:0] ch2_data;
  logic [DW-1:0] dac_data;
  logic dac_addr;
  logic cs_n;
  logic r_w_n;
  logic loaddac_n;
  logic busy;
  logic frame_done;
  logic [OVF_W-1:0] ovf_cnt;
  modport master (
    output enable, sample_tick, ch1_data, ch2_data,
    input dac_data, dac_addr, cs_n, r_w_n, loaddac_n, busy, frame_done, ovf_cnt
  );
  modport slave (
    input enable, sample_tick, ch1_data, ch2_data,
    output dac_data, dac_addr, cs_n, r_w_n, loaddac_n, busy, frame_done, ovf_cnt
  );
endinterface

// File: rtl/dac_phase_timer.sv
// dac_phase_timer: loadable down-counter; tc_o is high in the last cycle of a timed phase.
module dac_phase_timer #(
  parameter int TW = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load_i,
  input  logic [TW-1:0] val_i,
  output logic          tc_o
);
  logic [TW-1:0] cnt_q;
  always_ff @(posedge clk)
    if (rst) cnt_q <= '0;
    else if (load_i) cnt_q <= val_i;
    else if (cnt_q != '0) cnt_q <= cnt_q - 1'b1;
  assign tc_o = cnt_q == '0;
endmodule

// File: rtl/dac_dual_write_sched.sv
// dac_dual_write_sched: writes both DDS channel snapshots to DAC regs A/B, then pulses LOADDAC.
// Optional DAC_OFFSET_BIN_EN: convert two's complement samples to offset binary at capture.
module dac_dual_write_sched import dds_dac_pkg::*; #(
  parameter int DW = DAC_DW,
  parameter int SETUP_CYC = DAC_SETUP_CYC,
  parameter int WR_CYC = DAC_WR_CYC,
  parameter int HOLD_CYC = DAC_HOLD_CYC,
  parameter int LOAD_CYC = DAC_LOAD_CYC,
  parameter int OVF_W = DAC_OVF_W
) (
  input logic sys_clk,
  input logic rst,
  dac_dual_write_sched_if.slave bus
);
  localparam int TW = $clog2(max4(SETUP_CYC, WR_CYC, HOLD_CYC, LOAD_CYC)) + 1;
  function automatic logic [DW-1:0] conv(input logic [DW-1:0] w);
`ifdef DAC_OFFSET_BIN_EN
    return {~w[DW-1], w[DW-2:0]};
`else
    return w;
`endif
  endfunction
  dac_state_e state_q, state_d;
  logic ch_q, ch_d;
  logic [DW-1:0] snap_q [2];
  logic [DW-1:0] dac_data_q, dac_data_d;
  logic dac_addr_q, dac_addr_d;
  logic cs_n_q, cs_n_d, r_w_n_q, r_w_n_d, loaddac_n_q, loaddac_n_d;
  logic busy_q, busy_d, frame_done_q, frame_done_d;
  logic [OVF_W-1:0] ovf_q, ovf_d;
  logic accept, tick, tc, tload;
  logic [TW-1:0] tval;
  assign tick = bus.enable && bus.sample_tick;
  assign accept = tick && state_q == IDLE;
  dac_phase_timer #(.TW(TW)) u_timer (
    .clk(sys_clk), .rst(rst), .load_i(tload), .val_i(tval), .tc_o(tc)
  );
  always_ff @(posedge sys_clk)
    if (rst) state_q <= IDLE;
    else state_q <= state_d;
  always_comb begin
    state_d = state_q;
    ch_d = accept ? DAC_ADDR_A : ch_q;
    unique case (state_q)
      IDLE:  state_d = accept ? SETUP : IDLE;
      SETUP: state_d = tc ? WRITE : SETUP;
      WRITE: state_d = tc ? HOLD : WRITE;
      HOLD:  begin
        state_d = tc ? (ch_q ? LOAD : SETUP) : HOLD;
        ch_d = (tc && !ch_q) ? DAC_ADDR_B : ch_q;
      end
      LOAD:  state_d = tc ? DONE : LOAD;
      DONE:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  // Outputs are registered from the next state so pins line up with the state they belong to.
  always_comb begin
    tload = state_d != state_q;
    tval = state_d == SETUP ? TW'(SETUP_CYC - 1) :
           state_d == WRITE ? TW'(WR_CYC - 1) :
           state_d == HOLD  ? TW'(HOLD_CYC - 1) :
           state_d == LOAD  ? TW'(LOAD_CYC - 1) : '0;
    dac_data_d = accept ? conv(bus.ch1_data) :
                 state_d == SETUP ? snap_q[ch_d] : dac_data_q;
    dac_addr_d = state_d == SETUP ? ch_d : dac_addr_q;
    cs_n_d = state_d != WRITE;
    r_w_n_d = !(state_d == SETUP || state_d == WRITE || state_d == HOLD);
    loaddac_n_d = state_d != LOAD;
    busy_d = !(state_d == IDLE || state_d == DONE);
    frame_done_d = state_d == DONE;
    ovf_d = (tick && state_q != IDLE && ovf_q != '1) ? ovf_q + 1'b1 : ovf_q;
  end
  always_ff @(posedge sys_clk)
    if (rst) begin
      ch_q <= DAC_ADDR_A;
      snap_q[0] <= '0;
      snap_q[1] <= '0;
      dac_data_q <= '0;
      dac_addr_q <= DAC_ADDR_A;
      cs_n_q <= 1'b1;
      r_w_n_q <= 1'b1;
      loaddac_n_q <= 1'b1;
      busy_q <= 1'b0;
      frame_done_q <= 1'b0;
      ovf_q <= '0;
    end else begin
      ch_q <= ch_d;
      if (accept) begin
        snap_q[0] <= conv(bus.ch1_data);
        snap_q[1] <= conv(bus.ch2_data);
      end
      dac_data_q <= dac_data_d;
      dac_addr_q <= dac_addr_d;
      cs_n_q <= cs_n_d;
      r_w_n_q <= r_w_n_d;
      loaddac_n_q <= loaddac_n_d;
      busy_q <= busy_d;
      frame_done_q <= frame_done_d;
      ovf_q <= ovf_d;
    end
  assign bus.dac_data = dac_data_q;
  assign bus.dac_addr = dac_addr_q;
  assign bus.cs_n = cs_n_q;
  assign bus.r_w_n = r_w_n_q;
  assign bus.loaddac_n = loaddac_n_q;
  assign bus.busy = busy_q;
  assign bus.frame_done = frame_done_q;
  assign bus.ovf_cnt = ovf_q;
endmodule
